// File: rtl/dram_bridge.sv
// dram_bridge: turns MEM's single-cycle RAM strobe into a registered
// request/grant/response bus transaction. It stalls the pipeline while the
// transaction is outstanding and handles flushes and bus timeouts.
module dram_bridge #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_en,
    input  logic [3:0]  ram_write_en,
    input  logic [31:0] ram_addr,
    input  logic [31:0] ram_write_data,
    input  logic        flush,
    output logic        stall_req,
    output logic [31:0] ram_read_data,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    // Command fields latched at issue and held on the bus until grant
    typedef struct packed {
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_cmd_t;

    // The counter starts at 0 in the first REQ cycle, so the cycle that sees
    // CNT_LAST is the TIMEOUT_CYCLES-th cycle spent in REQ/RESP.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               discard, discard_nxt;
    bus_cmd_t           cmd, cmd_nxt;
    logic               req_nxt;
    logic [31:0]        rdata_nxt;
    logic               err_nxt;
    logic               stall_raw;
    logic               timeout;

    assign timeout = (cnt == CNT_LAST);
    assign {bus_wr, bus_wstrb, bus_addr, bus_wdata} = cmd;

    // Reset is folded in so the stall is also 0 while rst is held low
    assign stall_req = rst & ~flush & stall_raw;

    // Next-state, next register values and the raw stall request
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        discard_nxt = discard;
        cmd_nxt     = cmd;
        req_nxt     = bus_req;
        rdata_nxt   = ram_read_data;
        err_nxt     = 1'b0;
        stall_raw   = 1'b0;
        case (state)
            IDLE: begin
                if (ram_en && !flush) begin
                    stall_raw   = 1'b1;
                    cmd_nxt.wr    = |ram_write_en;
                    cmd_nxt.wstrb = ram_write_en;
                    cmd_nxt.addr  = ram_addr;
                    cmd_nxt.wdata = ram_write_data;
                    req_nxt     = 1'b1;
                    cnt_nxt     = '0;
                    discard_nxt = 1'b0;
                    state_nxt   = REQ;
                end
            end
            REQ: begin
                stall_raw = 1'b1;
                if (bus_gnt && bus_rvalid) begin
                    // Zero-wait slave: accepted and answered in one cycle
                    req_nxt = 1'b0;
                    cnt_nxt = '0;
                    if (flush) begin
                        state_nxt = IDLE;
                    end else begin
                        if (!cmd.wr) rdata_nxt = bus_rdata;
                        state_nxt = DONE;
                    end
                end else if (flush && !bus_gnt) begin
                    // Not yet accepted by the slave, so it can be withdrawn
                    req_nxt   = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (timeout) begin
                    req_nxt = 1'b0;
                    err_nxt = 1'b1;
                    cnt_nxt = '0;
                    if (flush) begin
                        state_nxt = IDLE;
                    end else begin
                        if (!cmd.wr) rdata_nxt = '0;
                        state_nxt = DONE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                    if (bus_gnt) begin
                        // Granted alongside a flush: response must still be
                        // consumed, but it is thrown away
                        req_nxt     = 1'b0;
                        discard_nxt = flush;
                        state_nxt   = RESP;
                    end
                end
            end
            RESP: begin
                stall_raw = ~discard;
                if (bus_rvalid) begin
                    cnt_nxt     = '0;
                    discard_nxt = 1'b0;
                    if (discard || flush) begin
                        state_nxt = IDLE;
                    end else begin
                        if (!cmd.wr) rdata_nxt = bus_rdata;
                        state_nxt = DONE;
                    end
                end else if (timeout) begin
                    err_nxt     = 1'b1;
                    cnt_nxt     = '0;
                    discard_nxt = 1'b0;
                    if (discard || flush) begin
                        state_nxt = IDLE;
                    end else begin
                        if (!cmd.wr) rdata_nxt = '0;
                        state_nxt = DONE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                    if (flush) discard_nxt = 1'b1;
                end
            end
            DONE: begin
                // One unstalled cycle lets MEM consume ram_read_data; ram_en
                // is still high for the same instruction, so never reissue
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and all registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            discard       <= 1'b0;
            cmd           <= '0;
            bus_req       <= 1'b0;
            ram_read_data <= '0;
            bus_err       <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            discard       <= discard_nxt;
            cmd           <= cmd_nxt;
            bus_req       <= req_nxt;
            ram_read_data <= rdata_nxt;
            bus_err       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_dram_bridge.sv
// Directed bench for dram_bridge: a per-cycle vector table for the normal,
// back-to-back and flush sequences, plus hand sequences for timeout
// (on a second instance with TIMEOUT_CYCLES=4) and mid-transaction reset.
module tb_dram_bridge;

    typedef struct packed {
        logic        stall;
        logic        req;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } obs_t;

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        flush;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        obs_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_en, en_to;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr, ram_write_data;
    logic        flush, bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    logic        stall_req, bus_err, bus_req, bus_wr;
    logic [31:0] ram_read_data, bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;

    logic        t_stall, t_err, t_req, t_wr;
    logic [31:0] t_rd, t_addr, t_wdata;
    logic [3:0]  t_wstrb;

    obs_t act, act_to;
    assign act    = {stall_req, bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata, ram_read_data, bus_err};
    assign act_to = {t_stall, t_req, t_wr, t_wstrb, t_addr, t_wdata, t_rd, t_err};

    int errors = 0;
    int checks = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    dram_bridge u_dut (
        .clk(clk), .rst(rst), .ram_en(ram_en), .ram_write_en(ram_write_en),
        .ram_addr(ram_addr), .ram_write_data(ram_write_data), .flush(flush),
        .stall_req(stall_req), .ram_read_data(ram_read_data), .bus_err(bus_err),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    dram_bridge #(.TIMEOUT_CYCLES(4), .CNT_W(3)) u_to (
        .clk(clk), .rst(rst), .ram_en(en_to), .ram_write_en(ram_write_en),
        .ram_addr(ram_addr), .ram_write_data(ram_write_data), .flush(flush),
        .stall_req(t_stall), .ram_read_data(t_rd), .bus_err(t_err),
        .bus_req(t_req), .bus_wr(t_wr), .bus_wstrb(t_wstrb),
        .bus_addr(t_addr), .bus_wdata(t_wdata), .bus_gnt(bus_gnt),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    function automatic obs_t o(input logic s, input logic r, input logic w, input logic [3:0] ws,
                               input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                               input logic e);
        return {s, r, w, ws, a, wd, rd, e};
    endfunction

    task automatic add(input logic en, input logic [3:0] wen, input logic [31:0] a, input logic [31:0] wd,
                       input logic f, input logic g, input logic v, input logic [31:0] rd, input obs_t e);
        vec_t t;
        t.en = en; t.wen = wen; t.addr = a; t.wdata = wd;
        t.flush = f; t.gnt = g; t.rv = v; t.rdata = rd; t.exp = e;
        vq.push_back(t);
    endtask

    task automatic drive(input logic en, input logic [3:0] wen, input logic [31:0] a, input logic [31:0] wd,
                         input logic f, input logic g, input logic v, input logic [31:0] rd);
        ram_en = en; ram_write_en = wen; ram_addr = a; ram_write_data = wd;
        flush = f; bus_gnt = g; bus_rvalid = v; bus_rdata = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int npulse;
        rst = 1'b0; en_to = 1'b0;
        drive(0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0);

        // Per-cycle vectors: inputs for the cycle, outputs expected in it
        // single read: grant in 2nd REQ cycle, rvalid 3 cycles later
        add(1, 4'h0, 32'h1000, 32'h0, 0, 0, 0, 32'h0, o(1, 0, 0, 4'h0, 32'h0,    32'h0, 32'h0, 0));
        add(1, 4'h0, 32'h1000, 32'h0, 0, 0, 0, 32'h0, o(1, 1, 0, 4'h0, 32'h1000, 32'h0, 32'h0, 0));
        add(1, 4'h0, 32'h1000, 32'h0, 0, 1, 0, 32'h0, o(1, 1, 0, 4'h0, 32'h1000, 32'h0, 32'h0, 0));
        add(1, 4'h0, 32'h1000, 32'h0, 0, 0, 0, 32'h0, o(1, 0, 0, 4'h0, 32'h1000, 32'h0, 32'h0, 0));
        add(1, 4'h0, 32'h1000, 32'h0, 0, 0, 0, 32'h0, o(1, 0, 0, 4'h0, 32'h1000, 32'h0, 32'h0, 0));
        add(1, 4'h0, 32'h1000, 32'h0, 0, 0, 1, 32'hDEADBEEF, o(1, 0, 0, 4'h0, 32'h1000, 32'h0, 32'h0, 0));
        add(1, 4'h0, 32'h1000, 32'h0, 0, 0, 0, 32'h0, o(0, 0, 0, 4'h0, 32'h1000, 32'h0, 32'hDEADBEEF, 0));
        add(0, 4'h0, 32'h0,    32'h0, 0, 0, 0, 32'h0, o(0, 0, 0, 4'h0, 32'h1000, 32'h0, 32'hDEADBEEF, 0));
        // single-byte write, zero-wait slave
        add(1, 4'h4, 32'h2000, 32'h00AB0000, 0, 0, 0, 32'h0, o(1, 0, 0, 4'h0, 32'h1000, 32'h0, 32'hDEADBEEF, 0));
        add(1, 4'h4, 32'h2000, 32'h00AB0000, 0, 1, 1, 32'h0, o(1, 1, 1, 4'h4, 32'h2000, 32'h00AB0000, 32'hDEADBEEF, 0));
        add(1, 4'h4, 32'h2000, 32'h00AB0000, 0, 0, 0, 32'h0, o(0, 0, 1, 4'h4, 32'h2000, 32'h00AB0000, 32'hDEADBEEF, 0));
        add(0, 4'h0, 32'h0,    32'h0,        0, 0, 0, 32'h0, o(0, 0, 1, 4'h4, 32'h2000, 32'h00AB0000, 32'hDEADBEEF, 0));
        // back-to-back read then write, zero-wait slave
        add(1, 4'h0, 32'h3000, 32'h0, 0, 0, 0, 32'h0,       o(1, 0, 1, 4'h4, 32'h2000, 32'h00AB0000, 32'hDEADBEEF, 0));
        add(1, 4'h0, 32'h3000, 32'h0, 0, 1, 1, 32'h11112222, o(1, 1, 0, 4'h0, 32'h3000, 32'h0, 32'hDEADBEEF, 0));
        add(1, 4'h0, 32'h3000, 32'h0, 0, 0, 0, 32'h0,       o(0, 0, 0, 4'h0, 32'h3000, 32'h0, 32'h11112222, 0));
        add(1, 4'hF, 32'h3004, 32'hCAFEF00D, 0, 0, 0, 32'h0, o(1, 0, 0, 4'h0, 32'h3000, 32'h0, 32'h11112222, 0));
        add(1, 4'hF, 32'h3004, 32'hCAFEF00D, 0, 1, 1, 32'h99999999, o(1, 1, 1, 4'hF, 32'h3004, 32'hCAFEF00D, 32'h11112222, 0));
        add(1, 4'hF, 32'h3004, 32'hCAFEF00D, 0, 0, 0, 32'h0, o(0, 0, 1, 4'hF, 32'h3004, 32'hCAFEF00D, 32'h11112222, 0));
        add(0, 4'h0, 32'h0,    32'h0,        0, 0, 0, 32'h0, o(0, 0, 1, 4'hF, 32'h3004, 32'hCAFEF00D, 32'h11112222, 0));
        // flush in REQ before grant, then flush in IDLE blocks issue
        add(1, 4'h0, 32'h4000, 32'h0, 0, 0, 0, 32'h0, o(1, 0, 1, 4'hF, 32'h3004, 32'hCAFEF00D, 32'h11112222, 0));
        add(1, 4'h0, 32'h4000, 32'h0, 1, 0, 0, 32'h0, o(0, 1, 0, 4'h0, 32'h4000, 32'h0, 32'h11112222, 0));
        add(0, 4'h0, 32'h0,    32'h0, 0, 0, 0, 32'h0, o(0, 0, 0, 4'h0, 32'h4000, 32'h0, 32'h11112222, 0));
        add(1, 4'h0, 32'h4000, 32'h0, 1, 0, 0, 32'h0, o(0, 0, 0, 4'h0, 32'h4000, 32'h0, 32'h11112222, 0));
        add(0, 4'h0, 32'h0,    32'h0, 0, 0, 0, 32'h0, o(0, 0, 0, 4'h0, 32'h4000, 32'h0, 32'h11112222, 0));
        // flush in RESP: response discarded, no stall
        add(1, 4'h0, 32'h5000, 32'h0, 0, 0, 0, 32'h0, o(1, 0, 0, 4'h0, 32'h4000, 32'h0, 32'h11112222, 0));
        add(1, 4'h0, 32'h5000, 32'h0, 0, 1, 0, 32'h0, o(1, 1, 0, 4'h0, 32'h5000, 32'h0, 32'h11112222, 0));
        add(0, 4'h0, 32'h0,    32'h0, 1, 0, 0, 32'h0, o(0, 0, 0, 4'h0, 32'h5000, 32'h0, 32'h11112222, 0));
        add(0, 4'h0, 32'h0,    32'h0, 0, 0, 0, 32'h0, o(0, 0, 0, 4'h0, 32'h5000, 32'h0, 32'h11112222, 0));
        add(0, 4'h0, 32'h0,    32'h0, 0, 0, 1, 32'h12345678, o(0, 0, 0, 4'h0, 32'h5000, 32'h0, 32'h11112222, 0));
        add(0, 4'h0, 32'h0,    32'h0, 0, 0, 0, 32'h0, o(0, 0, 0, 4'h0, 32'h5000, 32'h0, 32'h11112222, 0));
        // next read after a discard captures normally
        add(1, 4'h0, 32'h5008, 32'h0, 0, 0, 0, 32'h0,       o(1, 0, 0, 4'h0, 32'h5000, 32'h0, 32'h11112222, 0));
        add(1, 4'h0, 32'h5008, 32'h0, 0, 1, 1, 32'h0BADF00D, o(1, 1, 0, 4'h0, 32'h5008, 32'h0, 32'h11112222, 0));
        add(1, 4'h0, 32'h5008, 32'h0, 0, 0, 0, 32'h0,       o(0, 0, 0, 4'h0, 32'h5008, 32'h0, 32'h0BADF00D, 0));
        add(0, 4'h0, 32'h0,    32'h0, 0, 0, 0, 32'h0,       o(0, 0, 0, 4'h0, 32'h5008, 32'h0, 32'h0BADF00D, 0));

        // reset state of both instances, asserted from time 0
        #12;
        chk("reset dut", act, '0);
        chk("reset to", act_to, '0);
        @(negedge clk) rst = 1'b1;
        tick();

        foreach (vq[i]) begin
            drive(vq[i].en, vq[i].wen, vq[i].addr, vq[i].wdata, vq[i].flush, vq[i].gnt, vq[i].rv, vq[i].rdata);
            #1;
            chk($sformatf("vec%0d", i), act, vq[i].exp);
            tick();
        end

        // Timeout on the TIMEOUT_CYCLES=4 instance; first load a known read word
        drive(0, 4'h0, 32'h6000, 32'h0, 0, 0, 0, 32'h0);
        en_to = 1'b1; #1;
        chk("to issue stall", t_stall, 1);
        tick();
        drive(0, 4'h0, 32'h6000, 32'h0, 0, 1, 1, 32'hA5A5A5A5); #1;
        chk("to req addr", {t_req, t_addr}, {1'b1, 32'h6000});
        tick();
        drive(0, 4'h0, 32'h6000, 32'h0, 0, 0, 0, 32'h0); #1;
        chk("to done rd", {t_stall, t_rd}, {1'b0, 32'hA5A5A5A5});
        tick();
        drive(0, 4'h0, 32'h6004, 32'h0, 0, 0, 0, 32'h0); #1;
        chk("to issue2 stall", t_stall, 1);
        tick();
        npulse = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("to wait%0d", k), {t_stall, t_req, t_err}, 3'b110);
            npulse += int'(t_err);
            tick();
        end
        #1;
        chk("to done", {t_stall, t_req, t_err, t_rd}, {3'b001, 32'h0});
        npulse += int'(t_err);
        tick();
        en_to = 1'b0;
        drive(0, 4'h0, 32'h0, 32'h0, 0, 0, 1, 32'hFFFF0000); #1;
        chk("to idle err", {t_stall, t_err}, 2'b00);
        npulse += int'(t_err);
        tick();
        drive(0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0); #1;
        chk("to late rvalid ignored", {t_stall, t_req, t_rd}, {2'b00, 32'h0});
        chk("to err pulses", npulse, 1);
        tick();

        // Reset while in RESP on the main instance
        drive(1, 4'h0, 32'h7000, 32'h0, 0, 0, 0, 32'h0); tick();
        drive(1, 4'h0, 32'h7000, 32'h0, 0, 1, 1, 32'h55AA55AA); tick();
        drive(1, 4'h0, 32'h7000, 32'h0, 0, 0, 0, 32'h0); #1;
        chk("rst pre rd", ram_read_data, 32'h55AA55AA);
        tick();
        drive(1, 4'h0, 32'h7004, 32'h0, 0, 0, 0, 32'h0); tick();
        drive(1, 4'h0, 32'h7004, 32'h0, 0, 1, 0, 32'h0); tick();
        drive(1, 4'h0, 32'h7004, 32'h0, 0, 0, 0, 32'h0); #1;
        chk("rst pre resp", {stall_req, bus_req, bus_addr}, {2'b10, 32'h7004});
        #2 rst = 1'b0;
        #1;
        chk("rst async outputs", act, '0);
        @(negedge clk) rst = 1'b1;
        drive(0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
        tick();
        #1;
        chk("rst post idle", {stall_req, bus_req}, 2'b00);
        drive(1, 4'h0, 32'h7008, 32'h0, 0, 0, 0, 32'h0); #1;
        chk("rst post issue", stall_req, 1);
        tick();
        #1;
        chk("rst post req", {bus_req, bus_addr}, {1'b1, 32'h7008});
        drive(1, 4'h0, 32'h7008, 32'h0, 0, 1, 1, 32'h0); tick();
        drive(0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dram_bridge.md
Name: dram_bridge

Overview:
- Sits directly downstream of the MEM stage, between MEM's RAM control outputs (ram_en, ram_write_en, ram_addr, ram_write_data) and a multi-cycle data-bus slave.
- Converts MEM's single-cycle RAM interface into a registered request/grant/response transaction.
- Stalls the pipeline while a transaction is outstanding and returns the aligned word on ram_read_data, which feeds MEM's ram_read_data_in.
- Handles exception flush and bus timeout.

Parameters:
TIMEOUT_CYCLES, 255, cycles spent in REQ+RESP before a transaction is forcibly completed with an error
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-low reset
ram_en  input  1  from MEM: access request this cycle
ram_write_en  input  4  from MEM: byte write strobes, 0 means read
ram_addr  input  32  from MEM: word-aligned address
ram_write_data  input  32  from MEM: lane-aligned write data
flush  input  1  pipeline flush from exception/ERET commit
stall_req  output  1  to pipeline controller: hold all stages up to MEM
ram_read_data  output  32  to MEM: read word of last completed access
bus_err  output  1  one-cycle pulse: transaction timed out
bus_req  output  1  bus request, registered
bus_wr  output  1  1 = write, registered
bus_wstrb  output  4  byte strobes, registered
bus_addr  output  32  address, registered
bus_wdata  output  32  write data, registered
bus_gnt  input  1  slave accepted request this cycle
bus_rvalid  input  1  slave response (read data or write ack) this cycle
bus_rdata  input  32  read data, valid with bus_rvalid

Behaviour:
- Reset (rst low, asynchronous) puts the FSM in IDLE and clears the timeout counter and discard flag. Every output is 0: stall_req, ram_read_data, bus_err, bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata.
- States: IDLE, REQ, RESP, DONE.
- IDLE, issue condition: ram_en=1 and flush=0.
  - stall_req=1 combinationally in the same cycle.
  - Next edge: latch bus_addr=ram_addr, bus_wdata=ram_write_data, bus_wstrb=ram_write_en, bus_wr=|ram_write_en; set bus_req=1; go to REQ.
- IDLE, no issue: stay in IDLE with stall_req=0.
- REQ:
  - bus_req, bus_wr, bus_wstrb, bus_addr and bus_wdata are held stable until bus_gnt.
  - On bus_gnt: bus_req drops next edge. Go to RESP, or straight to DONE if bus_rvalid is also 1 that cycle (capture bus_rdata).
  - Flush before grant: abort. Drop bus_req, go to IDLE, no capture.
- RESP:
  - Wait for bus_rvalid. On it, reads capture ram_read_data<=bus_rdata; writes leave ram_read_data unchanged. Go to DONE.
  - Flush in RESP: the transaction cannot be aborted. Set the discard flag and keep waiting.
  - On the response with discard=1: no capture, go to IDLE, clear discard.
- DONE:
  - stall_req=0 for exactly one cycle, so the pipeline advances with ram_read_data valid.
  - No new issue is taken in DONE, even though ram_en is still high for the same instruction. Next state is always IDLE.
  - A back-to-back access is issued from IDLE on the following cycle.
- stall_req:
  - Value = (IDLE and ram_en and not flush) or REQ or RESP.
  - Forced to 0 whenever flush=1.
  - Forced to 0 in RESP while discard=1.
- Timeout:
  - The counter clears on entry to REQ and increments every cycle in REQ or RESP.
  - On reaching TIMEOUT_CYCLES: bus_err=1 for one cycle, bus_req=0, ram_read_data<=0 (reads), go to DONE. A timed-out discarded access goes to IDLE instead.
  - A bus_rvalid arriving after a timeout is ignored in IDLE.
- ram_read_data holds its value between captures.
- Minimum access latency: issue cycle + 1 REQ cycle (gnt and rvalid same cycle) + DONE, so 2 stall cycles.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. Slave-side recovery is out of scope.

Test Plan:
- Read addr 0x0000_1000, slave gnt after 2 cycles, rvalid 3 cycles later with 0xDEAD_BEEF -> stall_req high 6 cycles, bus_wr=0, ram_read_data=0xDEAD_BEEF in the DONE cycle with stall_req=0.
- Write strobes 4'b0100, data 0x00AB_0000, gnt+rvalid same cycle -> bus_wstrb=0100, bus_wr=1, 2 stall cycles, ram_read_data unchanged.
- Back-to-back read then write with zero-wait slave -> exactly one transaction each, DONE separates them, no duplicate bus_req.
- Flush during REQ before gnt -> bus_req drops next cycle, IDLE, no capture. Flush during RESP -> stall_req=0, response 0x1234_5678 discarded, ram_read_data unchanged.
- Slave never responds, TIMEOUT_CYCLES=4 -> bus_err pulses once after 4 cycles in REQ/RESP, ram_read_data=0, DONE then IDLE.
- rst asserted low while in RESP -> all outputs 0 asynchronously, FSM in IDLE after release.
